mc_control_fsm: RTL and testbench

Multi-cycle sequencer for the 32-bit MIPS datapath. It consumes the instruction decoder's control flags and the memory handshakes, and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the per-cycle enables (PC, IR, register file, memory request) and keeps a retired-instruction counter. Memory wait timeouts are trapped into a sticky HALT.

---
 rtl/mc_control_fsm_pkg.sv | 37 +++
 rtl/mc_wait_timer.sv | 39 +++
 rtl/mc_control_fsm.sv | 183 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// state codes, PC-source and write-back select codes, and the control strobe bundle.
package mc_control_fsm_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [1:0] PCSEL_PLUS4  = 2'd0;
    localparam logic [1:0] PCSEL_BRANCH = 2'd1;
    localparam logic [1:0] PCSEL_JUMP   = 2'd2;

    localparam logic WBSEL_ALU = 1'b0;
    localparam logic WBSEL_MEM = 1'b1;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic       wb_sel;
        logic       alu_src_sel;
    } ctrl_t;

    // States in which the sequencer is waiting on a memory handshake.
    function automatic logic is_wait_state(input logic [2:0] st);
        return (st == ST_FETCH) || (st == ST_MEM);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-handshake wait timer shared by FETCH and MEM; expired_o flags the
// last permitted wait cycle so the FSM can trap a missing ack.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Saturates at the limit so the count can never wrap back under it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and counts retirements.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             dec_jump,
    input  logic             dec_branch,
    input  logic             dec_memtoreg,
    input  logic             dec_memwrite,
    input  logic             dec_regwrite,
    input  logic             dec_alusrc,
    input  logic             branch_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             alu_src_sel,
    output logic [2:0]       state,
    output logic             busy,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    // state  | meaning
    // IDLE   | stopped between instructions, waiting for run
    // FETCH  | instruction fetch request outstanding
    // DECODE | decoder flags settle; jumps retire here
    // EXEC   | ALU cycle; branches and nops retire here
    // MEM    | data memory access outstanding; stores retire here
    // WB     | register file write; loads and ALU ops retire here
    // HALT   | bus timeout trapped, held until reset

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic             bus_err_q;
    logic             bus_err_d;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;

    ctrl_t      ctrl;
    logic [2:0] retire_state;
    logic       timeout;
    logic       wait_ack;
    logic       in_wait;
    logic       tmr_expired;

    assign in_wait  = is_wait_state(state_q);
    assign wait_ack = ((state_q == ST_FETCH) && imem_ack) ||
                      ((state_q == ST_MEM)   && dmem_ack);

    mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!in_wait || wait_ack),
        .en_i      (in_wait && !wait_ack),
        .expired_o (tmr_expired)
    );

    // run only matters at an instruction boundary, i.e. on the retire cycle.
    assign retire_state = run ? ST_FETCH : ST_IDLE;

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        timeout = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ctrl.imem_req = 1'b1;
                if (imem_ack) begin
                    ctrl.ir_we = 1'b1;
                    state_d    = ST_DECODE;
                end else if (tmr_expired) begin
                    timeout = 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec_jump) begin
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_sel = PCSEL_JUMP;
                    state_d     = retire_state;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ctrl.alu_src_sel = dec_alusrc;
                if (dec_branch) begin
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_sel = branch_taken ? PCSEL_BRANCH : PCSEL_PLUS4;
                    state_d     = retire_state;
                end else if (dec_memtoreg || dec_memwrite) begin
                    state_d = ST_MEM;
                end else if (dec_regwrite) begin
                    state_d = ST_WB;
                end else begin
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_sel = PCSEL_PLUS4;
                    state_d     = retire_state;
                end
            end
            ST_MEM: begin
                ctrl.dmem_req = 1'b1;
                ctrl.dmem_we  = dec_memwrite;
                if (dmem_ack) begin
                    if (dec_memtoreg) begin
                        state_d = ST_WB;
                    end else begin
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_sel = PCSEL_PLUS4;
                        state_d     = retire_state;
                    end
                end else if (tmr_expired) begin
                    timeout = 1'b1;
                end
            end
            ST_WB: begin
                ctrl.rf_we  = 1'b1;
                ctrl.wb_sel = dec_memtoreg ? WBSEL_MEM : WBSEL_ALU;
                ctrl.pc_we  = 1'b1;
                ctrl.pc_sel = PCSEL_PLUS4;
                state_d     = retire_state;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (timeout) begin
            state_d = ST_HALT;
        end
    end

    assign bus_err_d = bus_err_q | timeout;
    assign instret_d = ctrl.pc_we ? (instret_q + {{(CNT_W-1){1'b0}}, 1'b1}) : instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

    assign imem_req    = ctrl.imem_req;
    assign dmem_req    = ctrl.dmem_req;
    assign dmem_we     = ctrl.dmem_we;
    assign ir_we       = ctrl.ir_we;
    assign pc_we       = ctrl.pc_we;
    assign pc_sel      = ctrl.pc_sel;
    assign rf_we       = ctrl.rf_we;
    assign wb_sel      = ctrl.wb_sel;
    assign alu_src_sel = ctrl.alu_src_sel;
    assign state       = state_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign bus_err     = bus_err_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: expected per-cycle outputs are queued as
// each step is driven and popped for comparison when the cycle is sampled.
module tb_mc_control_fsm;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6;
    localparam logic [1:0] PS4 = 2'd0, PSB = 2'd1, PSJ = 2'd2;
    localparam logic H = 1'b1, L = 1'b0;

    logic             clk;
    logic             rst_n;
    logic             run;
    logic             dec_jump, dec_branch, dec_memtoreg, dec_memwrite, dec_regwrite, dec_alusrc;
    logic             branch_taken, imem_ack, dmem_ack;
    logic             imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, wb_sel, alu_src_sel;
    logic [1:0]       pc_sel;
    logic [2:0]       state;
    logic             busy, bus_err;
    logic [CNT_W-1:0] instret;

    mc_control_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .dec_jump     (dec_jump),
        .dec_branch   (dec_branch),
        .dec_memtoreg (dec_memtoreg),
        .dec_memwrite (dec_memwrite),
        .dec_regwrite (dec_regwrite),
        .dec_alusrc   (dec_alusrc),
        .branch_taken (branch_taken),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_src_sel  (alu_src_sel),
        .state        (state),
        .busy         (busy),
        .bus_err      (bus_err),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0]      vec;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    exp_t             sb[$];
    int               n_assert = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] exp_instret = '0;
    logic [14:0]      obs;

    assign obs = {state, busy, bus_err, imem_req, dmem_req, dmem_we, ir_we, pc_we,
                  pc_sel, rf_we, wb_sel, alu_src_sel};

    // {state, busy, bus_err, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_src_sel}
    function automatic logic [14:0] mk(input logic [2:0] st, input logic berr, input logic imem,
                                       input logic dmem, input logic dwe, input logic irwe,
                                       input logic pcwe, input logic [1:0] pcsel, input logic rfwe,
                                       input logic wbsel, input logic alu);
        logic busy_e;
        busy_e = (st != S_IDLE) && (st != S_HALT);
        return {st, busy_e, berr, imem, dmem, dwe, irwe, pcwe, pcsel, rfwe, wbsel, alu};
    endfunction

    task automatic push_exp(input string tag, input logic [14:0] ev);
        exp_t e;
        e.vec = ev;
        e.cnt = exp_instret;
        e.tag = tag;
        sb.push_back(e);
        if (ev[5]) exp_instret = exp_instret + 1;
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        n_assert++;
        assert (obs === e.vec) else begin
            n_fail++;
            $error("FAIL %s ctrl: observed %h expected %h", e.tag, obs, e.vec);
        end
        n_assert++;
        assert (instret === e.cnt) else begin
            n_fail++;
            $error("FAIL %s instret: observed %0d expected %0d", e.tag, instret, e.cnt);
        end
    endtask

    task automatic cyc(input string tag, input logic [14:0] ev);
        push_exp(tag, ev);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [14:0] ev);
        push_exp(tag, ev);
        pop_check();
    endtask

    task automatic set_flags(input logic j, input logic b, input logic m2r, input logic mw,
                             input logic rw, input logic as);
        dec_jump = j; dec_branch = b; dec_memtoreg = m2r;
        dec_memwrite = mw; dec_regwrite = rw; dec_alusrc = as;
    endtask

    logic [14:0] V_IDLE, V_F, V_F_IR, V_D;
    initial begin
        V_IDLE = mk(S_IDLE,  L, L, L, L, L, L, PS4, L, L, L);
        V_F    = mk(S_FETCH, L, H, L, L, L, L, PS4, L, L, L);
        V_F_IR = mk(S_FETCH, L, H, L, L, H, L, PS4, L, L, L);
        V_D    = mk(S_DECODE, L, L, L, L, L, L, PS4, L, L, L);

        rst_n = 1'b0; run = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        set_flags(L, L, L, L, L, L);
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", V_IDLE);
        rst_n = 1'b1;
        cyc("idle_run0", V_IDLE);

        // ADD: F, D, E, WB
        run = 1'b1;
        set_flags(L, L, L, L, H, L);
        cyc("add_idle", V_IDLE);
        imem_ack = 1'b1; cyc("add_fetch", V_F_IR);
        imem_ack = 1'b0; cyc("add_decode", V_D);
        cyc("add_exec", mk(S_EXEC, L, L, L, L, L, L, PS4, L, L, L));
        cyc("add_wb", mk(S_WB, L, L, L, L, L, H, PS4, H, L, L));

        // LW with dmem_ack three cycles late
        set_flags(L, L, H, L, H, H);
        imem_ack = 1'b1; cyc("lw_fetch", V_F_IR);
        imem_ack = 1'b0; cyc("lw_decode", V_D);
        cyc("lw_exec", mk(S_EXEC, L, L, L, L, L, L, PS4, L, L, H));
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", mk(S_MEM, L, L, H, L, L, L, PS4, L, L, L));
        dmem_ack = 1'b1; cyc("lw_mem_ack", mk(S_MEM, L, L, H, L, L, L, PS4, L, L, L));
        dmem_ack = 1'b0; cyc("lw_wb", mk(S_WB, L, L, L, L, L, H, PS4, H, H, L));

        // SW retires in MEM
        set_flags(L, L, L, H, L, H);
        imem_ack = 1'b1; cyc("sw_fetch", V_F_IR);
        imem_ack = 1'b0; cyc("sw_decode", V_D);
        cyc("sw_exec", mk(S_EXEC, L, L, L, L, L, L, PS4, L, L, H));
        dmem_ack = 1'b1; cyc("sw_mem", mk(S_MEM, L, L, H, H, L, H, PS4, L, L, L));
        dmem_ack = 1'b0;

        // Branch taken, then not taken with memory/regwrite flags also set
        set_flags(L, H, L, L, L, L);
        branch_taken = 1'b1;
        imem_ack = 1'b1; cyc("bt_fetch", V_F_IR);
        imem_ack = 1'b0; cyc("bt_decode", V_D);
        cyc("bt_exec", mk(S_EXEC, L, L, L, L, L, H, PSB, L, L, L));
        set_flags(L, H, L, H, H, L);
        branch_taken = 1'b0;
        imem_ack = 1'b1; cyc("bnt_fetch", V_F_IR);
        imem_ack = 1'b0; cyc("bnt_decode", V_D);
        cyc("bnt_exec", mk(S_EXEC, L, L, L, L, L, H, PS4, L, L, L));

        // Jump with run dropped during DECODE
        set_flags(H, L, L, L, H, L);
        imem_ack = 1'b1; cyc("jmp_fetch", V_F_IR);
        imem_ack = 1'b0; run = 1'b0;
        cyc("jmp_decode", mk(S_DECODE, L, L, L, L, L, H, PSJ, L, L, L));
        cyc("jmp_idle", V_IDLE);

        // NOP retires in EXEC
        set_flags(L, L, L, L, L, L);
        run = 1'b1;
        cyc("nop_idle", V_IDLE);
        imem_ack = 1'b1; cyc("nop_fetch", V_F_IR);
        imem_ack = 1'b0; cyc("nop_decode", V_D);
        cyc("nop_exec", mk(S_EXEC, L, L, L, L, L, H, PS4, L, L, L));

        // imem_ack on the limit cycle; a stray dmem_ack meanwhile is ignored
        dmem_ack = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) cyc("lim_fetch_wait", V_F);
        dmem_ack = 1'b0; imem_ack = 1'b1;
        cyc("lim_fetch_ack", V_F_IR);
        imem_ack = 1'b0;
        cyc("lim_decode", V_D);
        cyc("lim_exec", mk(S_EXEC, L, L, L, L, L, H, PS4, L, L, L));

        // No ack: HALT after MEM_TIMEOUT fetch cycles, sticky
        for (int i = 0; i < MEM_TIMEOUT; i++) cyc("to_fetch_wait", V_F);
        imem_ack = 1'b1; dmem_ack = 1'b1;
        for (int i = 0; i < 3; i++) cyc("halt_hold", mk(S_HALT, H, L, L, L, L, L, PS4, L, L, L));
        imem_ack = 1'b0; dmem_ack = 1'b0;

        rst_n = 1'b0;
        exp_instret = '0;
        #1;
        check_now("halt_async_rst", V_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load into MEM, then reset while dmem_req is high
        set_flags(L, L, H, L, H, H);
        cyc("ld2_idle", V_IDLE);
        imem_ack = 1'b1; cyc("ld2_fetch", V_F_IR);
        imem_ack = 1'b0; cyc("ld2_decode", V_D);
        cyc("ld2_exec", mk(S_EXEC, L, L, L, L, L, L, PS4, L, L, H));
        cyc("ld2_mem", mk(S_MEM, L, L, H, L, L, L, PS4, L, L, L));
        rst_n = 1'b0;
        exp_instret = '0;
        #1;
        check_now("mem_async_rst", V_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rst_idle", V_IDLE);
        cyc("rst_fetch", V_F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
